// File: rtl/te_ingress_checker_if.sv
// rtl/te_ingress_checker_if.sv - E-Trace ingress block bus between uop-to-ingress fsm and checker
interface te_ingress_checker_if #(
  parameter int XLEN        = 32,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2
);
  logic                   valid_i;
  logic [IRETIRE_LEN-1:0] iretire_i;
  logic                   ilastsize_i;
  logic [ITYPE_LEN-1:0]   itype_i;
  logic [CAUSE_LEN-1:0]   cause_i;
  logic [XLEN-1:0]        tval_i;
  logic [PRIV_LEN-1:0]    priv_i;
  logic [XLEN-1:0]        iaddr_i;

  modport master (
    output valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i
  );

  modport slave (
    input valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i
  );
endinterface

// File: rtl/te_ingress_checker.sv
// rtl/te_ingress_checker.sv - decodes ingress blocks into retirement records, checks continuity, buffers in a show-ahead FIFO
module te_ingress_checker #(
  parameter int FIFO_DEPTH  = 4,
  parameter int XLEN        = 32,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2,
  parameter int CNT_LEN     = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  te_ingress_checker_if.slave  ing,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [XLEN-1:0]      start_addr_o,
  output logic [XLEN-1:0]      last_addr_o,
  output logic [XLEN-1:0]      next_addr_o,
  output logic [ITYPE_LEN-1:0] itype_o,
  output logic [CAUSE_LEN-1:0] cause_o,
  output logic [XLEN-1:0]      tval_o,
  output logic [PRIV_LEN-1:0]  priv_o,
  output logic                 trap_o,
  output logic                 discont_o,
  output logic                 overflow_o,
  output logic [CNT_LEN-1:0]   hw_count_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]      start_addr;
    logic [XLEN-1:0]      last_addr;
    logic [XLEN-1:0]      next_addr;
    logic [ITYPE_LEN-1:0] itype;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
    logic                 trap;
    logic                 discont;
  } rec_t;

  rec_t             mem [FIFO_DEPTH];
  rec_t             new_rec;
  rec_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             full;
  logic             push;
  logic             pop;
  logic             exp_valid;
  logic             exp_seq;
  logic [XLEN-1:0]  exp_addr;
  logic             new_seq;
  logic [XLEN-1:0]  size;
  logic [XLEN-1:0]  span;

  assign full    = (occ == OCC_W'(FIFO_DEPTH));
  assign valid_o = (occ != '0);
  assign pop     = valid_o & ready_i;
  // A full FIFO still accepts a block when the head leaves in the same cycle.
  assign push    = ing.valid_i & (~full | pop);

  always_comb begin
    new_rec            = '0;
    size               = ing.ilastsize_i ? XLEN'(4) : XLEN'(2);
    span               = XLEN'(ing.iretire_i) << 1;
    new_rec.start_addr = ing.iaddr_i;
    new_rec.itype      = ing.itype_i;
    new_rec.cause      = ing.cause_i;
    new_rec.tval       = ing.tval_i;
    new_rec.priv       = ing.priv_i;
    new_rec.trap       = (ing.itype_i == ITYPE_LEN'(1)) || (ing.itype_i == ITYPE_LEN'(2));
    if (ing.iretire_i != '0) begin
      new_rec.last_addr = ing.iaddr_i + span - size;
      new_rec.next_addr = ing.iaddr_i + span;
    end else begin
      new_rec.last_addr = ing.iaddr_i;
      new_rec.next_addr = ing.iaddr_i;
    end
    new_rec.discont = exp_valid & exp_seq & (ing.iaddr_i != exp_addr);
    // Only sequential fall-through and not-taken branches predict the next block's start.
    new_seq = (ing.itype_i == ITYPE_LEN'(0)) || (ing.itype_i == ITYPE_LEN'(4));
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow_o <= 1'b0;
      hw_count_o <= '0;
      exp_valid  <= 1'b0;
      exp_seq    <= 1'b0;
      exp_addr   <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        hw_count_o <= hw_count_o + CNT_LEN'(ing.iretire_i);
        exp_valid  <= 1'b1;
        exp_seq    <= new_seq;
        exp_addr   <= new_rec.next_addr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (ing.valid_i && full && !pop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  assign head         = valid_o ? mem[rd_ptr] : '0;
  assign start_addr_o = head.start_addr;
  assign last_addr_o  = head.last_addr;
  assign next_addr_o  = head.next_addr;
  assign itype_o      = head.itype;
  assign cause_o      = head.cause;
  assign tval_o       = head.tval;
  assign priv_o       = head.priv;
  assign trap_o       = head.trap;
  assign discont_o    = head.discont;

endmodule

// File: tb/tb_te_ingress_checker.sv
// tb/tb_te_ingress_checker.sv - directed-vector bench for te_ingress_checker
module tb_te_ingress_checker;
  logic        clk_i;
  logic        rst_ni;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] start_addr_o;
  logic [31:0] last_addr_o;
  logic [31:0] next_addr_o;
  logic [2:0]  itype_o;
  logic [4:0]  cause_o;
  logic [31:0] tval_o;
  logic [1:0]  priv_o;
  logic        trap_o;
  logic        discont_o;
  logic        overflow_o;
  logic [63:0] hw_count_o;

  int checks = 0;
  int fails  = 0;

  te_ingress_checker_if ing ();

  te_ingress_checker dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .ing          (ing),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .start_addr_o (start_addr_o),
    .last_addr_o  (last_addr_o),
    .next_addr_o  (next_addr_o),
    .itype_o      (itype_o),
    .cause_o      (cause_o),
    .tval_o       (tval_o),
    .priv_o       (priv_o),
    .trap_o       (trap_o),
    .discont_o    (discont_o),
    .overflow_o   (overflow_o),
    .hw_count_o   (hw_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic drive_blk(input logic [31:0] addr, input logic [31:0] ret, input logic sz,
                           input logic [2:0] ity, input logic [4:0] cs, input logic [31:0] tv,
                           input logic [1:0] pv);
    ing.iaddr_i     = addr;
    ing.iretire_i   = ret;
    ing.ilastsize_i = sz;
    ing.itype_i     = ity;
    ing.cause_i     = cs;
    ing.tval_i      = tv;
    ing.priv_i      = pv;
    ing.valid_i     = 1'b1;
    @(posedge clk_i);
    #1;
    ing.valid_i     = 1'b0;
  endtask

  task automatic pop_one();
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++;
    if (overflow_o !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    checks++;
    if (hw_count_o !== 64'd0) begin fails++; $display("FAIL reset_hw_count: got %0d expected 0", hw_count_o); end
    checks++;
    if ({start_addr_o, last_addr_o, next_addr_o, trap_o, discont_o} !== 98'd0) begin
      fails++; $display("FAIL reset_record_zero: got start %h last %h next %h expected all 0", start_addr_o, last_addr_o, next_addr_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    drive_blk(32'h1000, 32'd6, 1'b1, 3'd0, 5'd0, 32'd0, 2'd0);
    checks++;
    if (valid_o !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b expected 1", valid_o); end
    checks++;
    if (last_addr_o !== 32'h1008) begin fails++; $display("FAIL basic_last: got %h expected 00001008", last_addr_o); end
    checks++;
    if (next_addr_o !== 32'h100C) begin fails++; $display("FAIL basic_next: got %h expected 0000100c", next_addr_o); end
    checks++;
    if (discont_o !== 1'b0) begin fails++; $display("FAIL basic_discont: got %b expected 0", discont_o); end
    checks++;
    if (hw_count_o !== 64'd6) begin fails++; $display("FAIL basic_hw_count: got %0d expected 6", hw_count_o); end
    #3;
    checks++;
    if (start_addr_o !== 32'h1000) begin fails++; $display("FAIL basic_stable: got %h expected 00001000", start_addr_o); end
    pop_one();
    checks++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL basic_popped: got %b expected 0", valid_o); end
  endtask

  task automatic test_continuity();
    logic [31:0] exp_start [3];
    logic [31:0] exp_last [3];
    logic        exp_disc [3];
    exp_start = '{32'h100C, 32'h2000, 32'h3000};
    exp_last  = '{32'h100E, 32'h2000, 32'h3000};
    exp_disc  = '{1'b0, 1'b0, 1'b1};
    drive_blk(32'h100C, 32'd2, 1'b0, 3'd5, 5'd0, 32'd0, 2'd0);
    drive_blk(32'h2000, 32'd2, 1'b1, 3'd0, 5'd0, 32'd0, 2'd0);
    drive_blk(32'h3000, 32'd1, 1'b0, 3'd0, 5'd0, 32'd0, 2'd0);
    checks++;
    if (hw_count_o !== 64'd11) begin fails++; $display("FAIL cont_hw_count: got %0d expected 11", hw_count_o); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (start_addr_o !== exp_start[i] || last_addr_o !== exp_last[i] || discont_o !== exp_disc[i]) begin
        fails++;
        $display("FAIL cont_rec%0d: got start %h last %h disc %b expected start %h last %h disc %b",
                 i, start_addr_o, last_addr_o, discont_o, exp_start[i], exp_last[i], exp_disc[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_trap();
    drive_blk(32'h80, 32'd0, 1'b1, 3'd1, 5'd2, 32'hDEAD, 2'd3);
    checks++;
    if (start_addr_o !== 32'h80 || last_addr_o !== 32'h80 || next_addr_o !== 32'h80) begin
      fails++; $display("FAIL trap_addrs: got %h %h %h expected 00000080 x3", start_addr_o, last_addr_o, next_addr_o);
    end
    checks++;
    if (trap_o !== 1'b1) begin fails++; $display("FAIL trap_flag: got %b expected 1", trap_o); end
    checks++;
    if (itype_o !== 3'd1 || cause_o !== 5'd2 || tval_o !== 32'hDEAD || priv_o !== 2'd3) begin
      fails++; $display("FAIL trap_fields: got itype %0d cause %0d tval %h priv %0d expected 1 2 0000dead 3", itype_o, cause_o, tval_o, priv_o);
    end
    checks++;
    if (discont_o !== 1'b1) begin fails++; $display("FAIL trap_discont: got %b expected 1", discont_o); end
    checks++;
    if (hw_count_o !== 64'd11) begin fails++; $display("FAIL trap_hw_count: got %0d expected 11", hw_count_o); end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      drive_blk(32'h4000 + 32'(i) * 32'h10, 32'd1, 1'b0, 3'd3, 5'd0, 32'd0, 2'd0);
    end
    checks++;
    if (overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
    checks++;
    if (hw_count_o !== 64'd15) begin fails++; $display("FAIL ovf_hw_count: got %0d expected 15", hw_count_o); end
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid_o !== 1'b1 || start_addr_o !== 32'h4000 + 32'(i) * 32'h10) begin
        fails++; $display("FAIL ovf_drain%0d: got valid %b start %h expected 1 %h", i, valid_o, start_addr_o, 32'h4000 + 32'(i) * 32'h10);
      end
      @(posedge clk_i);
      #1;
    end
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b expected 0", valid_o); end
    checks++;
    if (overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", overflow_o); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_blk(32'h5000 + 32'(i) * 32'h100, 32'd1, 1'b0, 3'd6, 5'd0, 32'd0, 2'd0);
    end
    ready_i = 1'b1;
    drive_blk(32'h5400, 32'd1, 1'b0, 3'd6, 5'd0, 32'd0, 2'd0);
    checks++;
    if (overflow_o !== 1'b0) begin fails++; $display("FAIL fpp_overflow: got %b expected 0", overflow_o); end
    checks++;
    if (hw_count_o !== 64'd5) begin fails++; $display("FAIL fpp_hw_count: got %0d expected 5", hw_count_o); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (valid_o !== 1'b1 || start_addr_o !== 32'h5000 + 32'(i) * 32'h100) begin
        fails++; $display("FAIL fpp_drain%0d: got valid %b start %h expected 1 %h", i, valid_o, start_addr_o, 32'h5000 + 32'(i) * 32'h100);
      end
      @(posedge clk_i);
      #1;
    end
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL fpp_empty: got %b expected 0", valid_o); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    drive_blk(32'hFFFF_FFFE, 32'd2, 1'b1, 3'd0, 5'd0, 32'd0, 2'd0);
    checks++;
    if (last_addr_o !== 32'hFFFF_FFFE) begin fails++; $display("FAIL wrap_last: got %h expected fffffffe", last_addr_o); end
    checks++;
    if (next_addr_o !== 32'h0000_0002) begin fails++; $display("FAIL wrap_next: got %h expected 00000002", next_addr_o); end
    drive_blk(32'h2, 32'd1, 1'b0, 3'd0, 5'd0, 32'd0, 2'd0);
    pop_one();
    checks++;
    if (valid_o !== 1'b1 || start_addr_o !== 32'h2 || discont_o !== 1'b0) begin
      fails++; $display("FAIL wrap_cont: got valid %b start %h disc %b expected 1 00000002 0", valid_o, start_addr_o, discont_o);
    end
    checks++;
    if (hw_count_o !== 64'd3) begin fails++; $display("FAIL wrap_hw_count: got %0d expected 3", hw_count_o); end
    ready_i = 1'b1;
    rst_ni  = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni  = 1'b1;
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", valid_o); end
    checks++;
    if (hw_count_o !== 64'd0) begin fails++; $display("FAIL midrst_hw_count: got %0d expected 0", hw_count_o); end
  endtask

  initial begin
    rst_ni          = 1'b0;
    ready_i         = 1'b0;
    ing.valid_i     = 1'b0;
    ing.iretire_i   = '0;
    ing.ilastsize_i = 1'b0;
    ing.itype_i     = '0;
    ing.cause_i     = '0;
    ing.tval_i      = '0;
    ing.priv_i      = '0;
    ing.iaddr_i     = '0;
    test_reset();
    test_basic();
    test_continuity();
    test_trap();
    test_overflow();
    test_full_push_pop();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/te_ingress_checker.md
Name: te_ingress_checker

Overview:
- Consumer end of the E-Trace ingress interface driven by the CVA6 uop-to-ingress `fsm`. Each cycle with `valid_i` high carries one ingress block.
- Buffers blocks in a small FIFO and decodes each into a retirement record: start address, last-instruction address, next sequential address and trap flag.
- Checks address continuity between consecutive blocks.
- Sits in the connector's self-check path and in the test harness. Output uses ready/valid toward a scoreboard or log sink.

Parameters:
- FIFO_DEPTH, 4, number of record entries; power of two, ≥2.
- XLEN, mure_pkg::XLEN, address/tval width.
- IRETIRE_LEN, mure_pkg::IRETIRE_LEN, width of the halfword retire count.
- ITYPE_LEN, mure_pkg::ITYPE_LEN (3), itype width.
- CAUSE_LEN, mure_pkg::CAUSE_LEN, cause width.
- PRIV_LEN, mure_pkg::PRIV_LEN, privilege width.
- CNT_LEN, 64, width of the retired-halfword counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  1  ingress block valid. No backpressure toward the producer.
- iretire_i  in  IRETIRE_LEN  halfwords retired in the block
- ilastsize_i  in  1  last instruction size: 0 = 2 B, 1 = 4 B
- itype_i  in  ITYPE_LEN  last instruction type: 0 none, 1 exc, 2 irq, 3 eret, 4 br-nt, 5 br-t, 6 uninferable jump
- cause_i  in  CAUSE_LEN  trap cause
- tval_i  in  XLEN  trap value
- priv_i  in  PRIV_LEN  privilege level
- iaddr_i  in  XLEN  address of the first instruction in the block
- valid_o  out  1  record available
- ready_i  in  1  sink accepts the record
- start_addr_o  out  XLEN  iaddr of the block
- last_addr_o  out  XLEN  address of the last instruction
- next_addr_o  out  XLEN  last_addr + last instruction size
- itype_o, cause_o, tval_o, priv_o  out  as inputs  forwarded fields
- trap_o  out  1  itype is 1 or 2
- discont_o  out  1  continuity violation detected on this record
- overflow_o  out  1  sticky: a block was dropped because the FIFO was full
- hw_count_o  out  CNT_LEN  total halfwords accepted since reset

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - FIFO empty, valid_o=0, overflow_o=0, hw_count_o=0, expectation register invalid.
  - All record outputs read 0 while the FIFO is empty.
  - Reset mid-operation discards all buffered records.
- Enqueue: on a valid_i cycle where the FIFO is not full, or is full with a pop in the same cycle, the decoded record is written.
- Decode at enqueue (combinational on inputs, stored in FIFO):
  - size = ilastsize_i ? 4 : 2.
  - If iretire_i ≠ 0: last_addr = iaddr + 2·iretire − size.
  - If iretire_i = 0: last_addr = next_addr = iaddr.
  - Otherwise next_addr = last_addr + size.
  - Arithmetic is modulo 2^XLEN; wrap-around is not an error.
- Continuity check:
  - Expectation register {exp_valid, exp_seq, exp_addr} is updated on every enqueued block: exp_addr = next_addr, exp_seq = (itype ∈ {0,4}), exp_valid = 1.
  - discont = exp_valid & exp_seq & (iaddr_i ≠ exp_addr), evaluated against the register value before the update.
  - Itypes 1, 2, 3, 5 and 6 (and unknown values 7+) clear exp_seq, so the following block is not checked.
  - Dropped blocks do not update the register.
- Counter: hw_count_o += iretire_i on each enqueue, zero-extended, wraps modulo 2^CNT_LEN.
- Overflow: valid_i while full with no pop in that cycle drops the block and sets overflow_o; it stays set until reset.
- Output: show-ahead FIFO head, registered.
  - A block enqueued at edge N into an empty FIFO gives valid_o=1 after edge N (1-cycle latency).
  - Pop occurs when valid_o & ready_i.
  - Outputs stay stable while valid_o & !ready_i.
  - Simultaneous push and pop when empty: the pushed record appears after the edge (no bypass).
  - When full, push+pop in the same cycle is accepted; occupancy is unchanged.
- Ordering is strictly FIFO.

Test Plan:
- Reset then one block iaddr=0x1000, iretire=6, ilastsize=1, itype=0 -> one cycle later valid_o=1, last_addr=0x1008, next=0x100C, discont=0, hw_count=6.
- Next block iaddr=0x100C, itype=5, followed by block iaddr=0x2000 -> both discont=0 (taken branch exempts the jump); then a block at iaddr=0x3000 after an itype=0 block ending at 0x2004 -> discont=1.
- Exception block iretire=0, itype=1, cause=2, tval=0xDEAD, iaddr=0x80 -> last=next=0x80, trap_o=1, fields forwarded unchanged.
- ready_i=0, five consecutive blocks with FIFO_DEPTH=4 -> first four held in order, fifth dropped, overflow_o=1 sticky; hw_count excludes the fifth; release ready_i -> four records drain in order.
- Full FIFO with ready_i=1 and valid_i=1 on the same cycle -> no drop, occupancy stays 4, overflow_o stays 0.
- iaddr=0xFFFF_FFFE (XLEN=32), iretire=2, ilastsize=1 -> last_addr=0xFFFF_FFFE, next_addr=0x0000_0002; rst_ni=0 mid-drain -> valid_o=0 and hw_count=0 after that edge.
